// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared op encoding for the pipelined bitwise logic unit.
//   OP_W  - width of the gate select field
//   op_e  - gate select values OP_AND .. OP_PASS_A
package logic_gate_pkg;
    localparam int OP_W = 3;
    typedef enum logic [OP_W-1:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_NAND   = 3'd2,
        OP_NOR    = 3'd3,
        OP_XOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;
endpackage

// File: rtl/logic_gate_alu.sv
// logic_gate_alu: combinational WIDTH-bit two-operand gate function.
//   a, b - operands
//   op   - gate select (logic_gate_pkg::op_e encoding)
//   y    - bitwise result
module logic_gate_alu
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [OP_W-1:0]  op,
    output logic [WIDTH-1:0] y
);
    always_comb begin
        y = '0;
        case (op)
            OP_AND:    y = a & b;
            OP_OR:     y = a | b;
            OP_NAND:   y = ~(a & b);
            OP_NOR:    y = ~(a | b);
            OP_XOR:    y = a ^ b;
            OP_XNOR:   y = ~(a ^ b);
            OP_NOT_A:  y = ~a;
            OP_PASS_A: y = a;
        endcase
    end
endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: two-stage valid/ready pipelined bitwise logic unit.
//   clk, rst_n            - clock, synchronous active-low reset
//   in_valid/in_ready     - operand-pair handshake (in_a, in_b, in_op)
//   out_valid/out_ready   - result handshake (out_data, out_zero, out_parity)
//   out_count             - accepted-result count, present only when
//                           LOGIC_GATE_PIPE_CNT_EN is defined, else tied to 0
module logic_gate_pipe
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [OP_W-1:0]  in_op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_count
);
    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic [OP_W-1:0]  s1_op;
    logic             s2_valid;
    logic             s2_ready;
    logic [WIDTH-1:0] alu_y;

    // Ready passes straight through from out_ready so a drained S2 frees S1
    // in the same cycle; neither depends on in_valid.
    assign s2_ready = !s2_valid || out_ready;
    assign in_ready = !s1_valid || s2_ready;
    assign out_valid = s2_valid;

    logic_gate_alu #(.WIDTH(WIDTH)) u_alu (
        .a  (s1_a),
        .b  (s1_b),
        .op (s1_op),
        .y  (alu_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_a       <= '0;
            s1_b       <= '0;
            s1_op      <= '0;
            s2_valid   <= 1'b0;
            out_data   <= '0;
            out_zero   <= 1'b1;
            out_parity <= 1'b0;
        end else begin
            // in_ready means S1 is empty or moving on this edge
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_a  <= in_a;
                    s1_b  <= in_b;
                    s1_op <= in_op;
                end
            end
            if (s2_ready) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_data   <= alu_y;
                    out_zero   <= ~|alu_y;
                    out_parity <= ^alu_y;
                end
            end
        end
    end

`ifdef LOGIC_GATE_PIPE_CNT_EN
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (!rst_n) cnt <= '0;
        else if (out_valid && out_ready) cnt <= cnt + CNT_W'(1);
    end
    assign out_count = cnt;
`else
    assign out_count = '0;
`endif
endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed and randomized checks of logic_gate_pipe against an in-order scoreboard.
module tb_logic_gate_pipe;
    localparam int WIDTH = 8;
    localparam int CNT_W = 4;
`ifdef LOGIC_GATE_PIPE_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic [2:0]       in_op = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_parity;
    logic [CNT_W-1:0] out_count;

    int n_checks = 0;
    int n_fail = 0;

    logic [WIDTH-1:0] q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    int               acc = 0;
    int               emt = 0;
    logic             stalled = 1'b0;
    logic [WIDTH-1:0] held = '0;

    logic_gate_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_zero   (out_zero),
        .out_parity (out_parity),
        .out_count  (out_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] gate(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a & b;
            3'd1: return a | b;
            3'd2: return ~(a & b);
            3'd3: return ~(a | b);
            3'd4: return a ^ b;
            3'd5: return ~(a ^ b);
            3'd6: return ~a;
            default: return a;
        endcase
    endfunction

    // Scoreboard: transfers are decided by the values seen just before the next rising edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete();
            exp_cnt = '0;
            acc = 0;
            emt = 0;
            stalled = 1'b0;
        end else begin
            check("count", 32'(out_count), CNT_EN ? 32'(exp_cnt) : 32'd0);
            if (stalled) check("hold", 32'(out_data), 32'(held));
            if (out_valid && out_ready) begin
                if (q.size() == 0) check("unexpected_out", 32'd1, 32'd0);
                else begin
                    logic [WIDTH-1:0] e;
                    e = q.pop_front();
                    check("data", 32'(out_data), 32'(e));
                    check("zero", 32'(out_zero), 32'(e == '0));
                    check("parity", 32'(out_parity), 32'(^e));
                end
                emt++;
                exp_cnt = exp_cnt + 1'b1;
            end
            if (in_valid && in_ready) begin
                q.push_back(gate(in_a, in_b, in_op));
                acc++;
            end
            stalled = out_valid && !out_ready;
            held = out_data;
        end
    end

    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [2:0] op);
        int n;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_op = op;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [WIDTH-1:0] seq_exp[8] = '{8'h30, 8'hFC, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'h0F, 8'hF0};

    initial begin
        int sent, cyc, base;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_data", 32'(out_data), 32'h00);
        check("rst_zero", 32'(out_zero), 32'd1);
        check("rst_parity", 32'(out_parity), 32'd0);
        check("rst_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;

        // All eight ops back-to-back on F0/3C
        for (int i = 0; i < 10; i++) begin
            in_valid = (i < 8);
            in_a = 8'hF0;
            in_b = 8'h3C;
            in_op = 3'(i);
            @(negedge clk);
            if (i < 2) check("lat_valid", 32'(out_valid), 32'd0);
            else begin
                check("seq_valid", 32'(out_valid), 32'd1);
                check("seq_data", 32'(out_data), 32'(seq_exp[i-2]));
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        send(8'hF0, 8'h0F, 3'd0);
        @(posedge clk);
        #1;
        check("and_valid", 32'(out_valid), 32'd1);
        check("and_data", 32'(out_data), 32'h00);
        check("and_zero", 32'(out_zero), 32'd1);
        check("and_parity", 32'(out_parity), 32'd0);
        send(8'h01, 8'h00, 3'd4);
        @(posedge clk);
        #1;
        check("xor_data", 32'(out_data), 32'h01);
        check("xor_zero", 32'(out_zero), 32'd0);
        check("xor_parity", 32'(out_parity), 32'd1);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: three pairs offered, two fit
        base = acc;
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'hAA; in_b = 8'h55; in_op = 3'd1;
        @(posedge clk); #1;
        in_a = 8'h0F; in_b = 8'hFF; in_op = 3'd0;
        @(posedge clk); #1;
        in_a = 8'h12; in_b = 8'h34; in_op = 3'd4;
        @(negedge clk);
        check("stall_ready", 32'(in_ready), 32'd0);
        check("stall_valid", 32'(out_valid), 32'd1);
        check("stall_data", 32'(out_data), 32'hFF);
        @(posedge clk); #1;
        @(negedge clk);
        check("stall_ready2", 32'(in_ready), 32'd0);
        check("stall_data2", 32'(out_data), 32'hFF);
        check("stall_accepted", 32'(acc - base), 32'd2);
        @(posedge clk); #1;
        out_ready = 1'b1;
        #1;
        check("release_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("release_data2", 32'(out_data), 32'h0F);
        @(posedge clk); #1;
        @(negedge clk);
        check("release_data3", 32'(out_data), 32'h26);
        repeat (3) @(posedge clk);
        #1;

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_a = 8'h11; in_b = 8'h22; in_op = 3'd1;
        @(posedge clk); #1;
        in_a = 8'h33; in_b = 8'h0F; in_op = 3'd0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mrst_valid", 32'(out_valid), 32'd0);
        check("mrst_ready", 32'(in_ready), 32'd1);
        check("mrst_data", 32'(out_data), 32'h00);
        check("mrst_zero", 32'(out_zero), 32'd1);
        check("mrst_count", 32'(out_count), 32'd0);
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("mrst_no_stale", 32'(emt), 32'd0);

        // 17 transfers wrap the 4-bit counter to 1
        for (int i = 0; i < 17; i++) send(8'(i), 8'h5A, 3'(i % 8));
        repeat (3) @(posedge clk);
        #1;
        check("wrap_count", 32'(out_count), CNT_EN ? 32'd1 : 32'd0);

        // Random valid/ready toggling
        sent = 0;
        cyc = 0;
        while (sent < 1000 && cyc < 20000) begin
            in_valid = ($urandom_range(0, 1) == 1);
            out_ready = ($urandom_range(0, 3) != 0);
            in_a = 8'($urandom);
            in_b = 8'($urandom);
            in_op = 3'($urandom);
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (cyc >= 20000) check("rand_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("drain_count", 32'(emt), 32'(acc));
        check("drain_queue", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
